// File: rtl/mac_requant_if.sv
// rtl/mac_requant_if.sv - MAC result input, bias load and output FIFO handshake bundle
interface mac_requant_if #(
  parameter int OUT_W = 8
);
  logic signed [31:0] mac_din;
  logic               mac_din_vld;
  logic signed [31:0] bias_din;
  logic               bias_vld;
  logic               relu_en;
  logic [OUT_W-1:0]   dout;
  logic               dout_last;
  logic               dout_vld;
  logic               dout_rdy;
  logic               fifo_full;
  logic               overflow;

  modport slave (
    input  mac_din, mac_din_vld, bias_din, bias_vld, relu_en, dout_rdy,
    output dout, dout_last, dout_vld, fifo_full, overflow
  );

  modport master (
    output mac_din, mac_din_vld, bias_din, bias_vld, relu_en, dout_rdy,
    input  dout, dout_last, dout_vld, fifo_full, overflow
  );
endinterface

// File: rtl/mac_requant.sv
// rtl/mac_requant.sv - bias add, ReLU, round-half-up shift, saturate, frame-tagged FWFT FIFO
module mac_requant #(
  parameter int FRAC_BITS  = 8,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_requant_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic signed [33:0] ROUND   = 34'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [33:0] SAT_MAX = (34'sd1 <<< (OUT_W - 1)) - 34'sd1;
  localparam logic signed [33:0] SAT_MIN = -(34'sd1 <<< (OUT_W - 1));
  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic signed [31:0] bias_q, bias_d;

  logic               s1_vld_q, s1_vld_d;
  logic signed [32:0] s1_sum_q, s1_sum_d;
  logic               s1_relu_q, s1_relu_d;

  logic               s2_vld_q, s2_vld_d;
  logic signed [33:0] s2_r_q, s2_r_d;
  logic signed [32:0] relu_sum;
  logic signed [33:0] sum34;

  logic [OUT_W-1:0]   sat;
  logic               last;
  logic [FC_W-1:0]    frame_q, frame_d;

  logic [OUT_W:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full;
  logic               not_empty;
  logic               push;
  logic               pop;

  // A sample arriving with bias_vld sees bias_q before the load takes effect.
  always_comb begin
    bias_d    = bus.bias_vld ? bus.bias_din : bias_q;
    s1_vld_d  = bus.mac_din_vld;
    s1_sum_d  = s1_sum_q;
    s1_relu_d = s1_relu_q;
    if (bus.mac_din_vld) begin
      s1_sum_d  = {bus.mac_din[31], bus.mac_din} + {bias_q[31], bias_q};
      s1_relu_d = bus.relu_en;
    end
  end

  always_comb begin
    relu_sum = (s1_relu_q && s1_sum_q[32]) ? 33'sd0 : s1_sum_q;
    sum34    = {relu_sum[32], relu_sum};
    s2_vld_d = s1_vld_q;
    s2_r_d   = s1_vld_q ? ((sum34 + ROUND) >>> FRAC_BITS) : s2_r_q;
  end

  always_comb begin
    sat = s2_r_q[OUT_W-1:0];
    if (s2_r_q > SAT_MAX) begin
      sat = SAT_MAX[OUT_W-1:0];
    end else if (s2_r_q < SAT_MIN) begin
      sat = SAT_MIN[OUT_W-1:0];
    end
  end

  // The frame counter follows write attempts, not accepted writes.
  always_comb begin
    last    = (frame_q == FC_LAST);
    frame_d = frame_q;
    if (s2_vld_q) begin
      frame_d = last ? '0 : frame_q + FC_W'(1);
    end
  end

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_FULL);
  assign pop       = not_empty && bus.dout_rdy;
  assign push      = s2_vld_q && (!full || pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q || (s2_vld_q && full && !pop);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bias_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_sum_q   <= '0;
      s1_relu_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_r_q     <= '0;
      frame_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      bias_q     <= bias_d;
      s1_vld_q   <= s1_vld_d;
      s1_sum_q   <= s1_sum_d;
      s1_relu_q  <= s1_relu_d;
      s2_vld_q   <= s2_vld_d;
      s2_r_q     <= s2_r_d;
      frame_q    <= frame_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {last, sat};
      end
    end
  end

  assign bus.dout      = mem_q[rd_ptr_q][OUT_W-1:0];
  assign bus.dout_last = mem_q[rd_ptr_q][OUT_W];
  assign bus.dout_vld  = not_empty;
  assign bus.fifo_full = full;
  assign bus.overflow  = overflow_q;

endmodule
